divider_seq: RTL and testbench

- Multi-cycle restoring integer divider for the ALU. It is the inverse operation of the N-bit adder datapath: one trial subtraction per cycle, with the carry-out used as the restore decision.
- Takes dividend and divisor on a start pulse and produces quotient and remainder after N iteration cycles.
- Sits beside the combinational adder and shifter in the ALU. The control unit stalls on busy and latches results on done.

---
 rtl/divider_seq.sv | 136 +++++++++++++
 tb/tb_divider_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// divider_seq: multi-cycle restoring integer divider (one trial subtraction per cycle).
// Optional build macro SIGNED_DIV_EN: two's complement operands, truncating quotient,
// remainder carries the sign of the dividend. Undefined: unsigned only.
module divider_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic [N-1:0]   rem_reg;
  logic [N-1:0]   quo_reg;
  logic [N-1:0]   div_reg;
  logic [CW-1:0]  cnt_reg;

  // One restoring step: the remainder is widened to N+1 bits so the shift cannot overflow,
  // and the carry-out of rem_shifted + ~b + 1 is the "no borrow" restore decision.
  logic [N:0]     rem_shifted;
  logic           no_borrow;
  logic           diff_unused;
  logic [N-1:0]   diff_low;
  logic [N-1:0]   rem_step;
  logic [N-1:0]   quo_step;
  logic [N-1:0]   q_final;
  logic [N-1:0]   r_final;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  assign rem_shifted = {rem_reg, quo_reg[N-1]};
  assign {no_borrow, diff_unused, diff_low} =
      {1'b0, rem_shifted} + {1'b0, ~{1'b0, div_reg}} + (N+2)'(1);
  // When no borrow occurs the difference is below the divisor, so the low N bits hold it all;
  // on a borrow the shifted remainder is below the divisor too.
  assign rem_step = no_borrow ? diff_low : rem_shifted[N-1:0];
  assign quo_step = {quo_reg[N-2:0], no_borrow};

`ifdef SIGNED_DIV_EN
  logic neg_q_reg;
  logic neg_r_reg;

  // Divide magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_mag   = a[N-1] ? -a : a;
  assign b_mag   = b[N-1] ? -b : b;
  // Sign fix-up is folded into the final register load so latency is unchanged.
  assign q_final = neg_q_reg ? -quo_step : quo_step;
  assign r_final = neg_r_reg ? -rem_step : rem_step;
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign q_final = quo_step;
  assign r_final = rem_step;
`endif

  // Control FSM with registered outputs; reset wins over everything, including mid-RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      cnt_reg     <= '0;
      q           <= '0;
      r           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            if (b == '0) begin
              // Divide-by-zero finishes immediately without entering RUN.
              q           <= '1;
              r           <= a;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state_reg   <= DONE;
            end else begin
              q           <= '0;
              r           <= '0;
              div_by_zero <= 1'b0;
              rem_reg     <= '0;
              quo_reg     <= a_mag;
              div_reg     <= b_mag;
              cnt_reg     <= '0;
              busy        <= 1'b1;
              state_reg   <= RUN;
`ifdef SIGNED_DIV_EN
              neg_q_reg   <= a[N-1] ^ b[N-1];
              neg_r_reg   <= a[N-1];
`endif
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1)) begin
            q         <= q_final;
            r         <= r_final;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed test-plan cases plus randomized operations against a
// plain-arithmetic reference model. Follows SIGNED_DIV_EN the same way the design does.
module tb_divider_seq;

  localparam int N = 16;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  divider_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a_in),
    .b           (b_in),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what the division should give, straight from arithmetic operators.
  function automatic void model(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                output logic [N-1:0] eq, output logic [N-1:0] er,
                                output logic ez);
`ifdef SIGNED_DIV_EN
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    sa = ta;
    sb = tb;
`endif
    ez = (tb == '0);
    if (ez) begin
      eq = '1;
      er = ta;
    end else begin
`ifdef SIGNED_DIV_EN
      if (ta == MIN_NEG && tb == '1) begin
        eq = MIN_NEG;
        er = '0;
      end else begin
        eq = sa / sb;
        er = sa % sb;
      end
`else
      eq = ta / tb;
      er = ta % tb;
`endif
    end
  endfunction

  // Called at the negedge after the accept edge; returns at the negedge where done is seen.
  // With poke set, start and operands are scrambled while busy to show they are ignored.
  task automatic wait_done(input bit poke, output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (poke) begin
        start = busy ? 1'($urandom) : 1'b0;
        a_in  = N'($urandom);
        b_in  = N'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic verify(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input int lat, input int busy_cnt);
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ez;
    model(ta, tb, eq, er, ez);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_latency"}, lat, ez ? 1 : N + 1);
    check({tag, "_busy_cycles"}, busy_cnt, ez ? 0 : N);
`ifndef SIGNED_DIV_EN
    if (!ez) begin
      check({tag, "_identity"}, 64'(q) * 64'(tb) + 64'(r), 64'(ta));
      check({tag, "_r_lt_b"}, r < tb, 1'b1);
    end
`endif
    $display("op %s a=0x%04h b=0x%04h q=0x%04h r=0x%04h dbz=%0d lat=%0d", tag, ta, tb, q, r,
             div_by_zero, lat);
  endtask

  // Single operation from idle, then confirm done drops and results hold.
  task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb);
    int lat;
    int bc;
    logic [N-1:0] q_seen;
    logic [N-1:0] r_seen;
    a_in  = ta;
    b_in  = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, lat, bc);
    start = 1'b0;
    verify(tag, ta, tb, lat, bc);
    q_seen = q;
    r_seen = r;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_q_hold"}, q, q_seen);
    check({tag, "_r_hold"}, r, r_seen);
  endtask

  initial begin
    int lat;
    int bc;
    int stray;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_q", q, '0);
    check("rst_r", r, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);

    do_op("a100_b7", 16'd100, 16'd7);
    do_op("ffff_b1", 16'hFFFF, 16'd1);
    do_op("a5_b9", 16'd5, 16'd9);
    do_op("div0", 16'd1234, 16'd0);

    // Back-to-back: start stays high, second operands presented in the DONE cycle.
    a_in  = 16'd50;
    b_in  = 16'd5;
    start = 1'b1;
    @(negedge clk);
    wait_done(1'b0, lat, bc);
    verify("b2b_first", 16'd50, 16'd5, lat, bc);
    a_in = 16'd51;
    @(negedge clk);
    wait_done(1'b0, lat, bc);
    start = 1'b0;
    verify("b2b_second", 16'd51, 16'd5, lat, bc);
    @(negedge clk);
    check("b2b_idle_done", done, 1'b0);

    // Reset in the middle of RUN.
    a_in  = 16'd1000;
    b_in  = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("midrun_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_done", done, 1'b0);
    check("midrun_rst_q", q, '0);
    check("midrun_rst_r", r, '0);
    stray = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    check("midrun_no_stray_activity", stray, 0);
    do_op("after_rst_a9_b3", 16'd9, 16'd3);

`ifdef SIGNED_DIV_EN
    do_op("s_m7_b2", 16'hFFF9, 16'd2);
    do_op("s_min_m1", 16'h8000, 16'hFFFF);
    do_op("s_7_m2", 16'd7, 16'hFFFE);
    do_op("s_m1234_b0", 16'hFB2E, 16'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = N'($urandom_range(1, 15));
        3:       rb = '1;
        default: rb = N'($urandom);
      endcase
      if (i % 10 == 9) ra = MIN_NEG;
      do_op("rand", ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
